// File: rtl/ghash_state_bank_if.sv
// Command and result handshake bundle for the multi-context GHASH state bank.
// The master issues commands and consumes results; the slave is the bank itself.
interface ghash_state_bank_if #(
  parameter int WIDTH   = 128,
  parameter int CH_W    = 2,
  parameter int COUNT_W = 8
);
  logic               op_valid;
  logic               op_ready;
  logic [1:0]         op_code;
  logic [CH_W-1:0]    op_ch;
  logic [WIDTH-1:0]   op_data;

  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] out_count;
  logic               out_err;

  modport master (
    output op_valid, op_code, op_ch, op_data, out_ready,
    input  op_ready, out_valid, out_ch, out_data, out_count, out_err
  );

  modport slave (
    input  op_valid, op_code, op_ch, op_data, out_ready,
    output op_ready, out_valid, out_ch, out_data, out_count, out_err
  );
endinterface

// File: rtl/ghash_state_bank.sv
// NCH independent GHASH accumulator contexts with saturating absorbed-block
// counters, driven by a command port and answering READs through a result register.
module ghash_state_bank #(
  parameter int WIDTH   = 128,
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int COUNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  ghash_state_bank_if.slave bus
);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_XOR   = 2'b10,
    OP_READ  = 2'b11
  } op_e;

  localparam logic [CH_W:0]      NCH_L     = (CH_W + 1)'(NCH);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic               accept;
  logic               ch_ok;
  op_e                op;

  logic [WIDTH-1:0]   state_q [NCH];
  logic [COUNT_W-1:0] count_q [NCH];

  logic [WIDTH-1:0]   rd_state;
  logic [COUNT_W-1:0] rd_count;

  logic               out_valid_q, out_valid_d;
  logic [CH_W-1:0]    out_ch_q,    out_ch_d;
  logic [WIDTH-1:0]   out_data_q,  out_data_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               out_err_q,   out_err_d;

  // A held result blocks every command so results are never overwritten.
  assign bus.op_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.op_valid & bus.op_ready;
  assign op           = op_e'(bus.op_code);
  assign ch_ok        = ({1'b0, bus.op_ch} < NCH_L);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic               hit;
    logic [WIDTH-1:0]   state_d;
    logic [COUNT_W-1:0] count_d;

    assign hit = accept && (bus.op_ch == CH_W'(gi));

    always_comb begin
      state_d = state_q[gi];
      count_d = count_q[gi];
      if (hit) begin
        unique case (op)
          OP_CLEAR: begin
            state_d = '0;
            count_d = '0;
          end
          OP_LOAD: begin
            state_d = bus.op_data;
            count_d = '0;
          end
          OP_XOR: begin
            state_d = state_q[gi] ^ bus.op_data;
            count_d = (count_q[gi] == COUNT_MAX) ? COUNT_MAX : count_q[gi] + 1'b1;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q[gi] <= '0;
        count_q[gi] <= '0;
      end else begin
        state_q[gi] <= state_d;
        count_q[gi] <= count_d;
      end
    end
  end

  // Explicit compare-mux keeps out-of-range channel indices from touching the arrays.
  always_comb begin
    rd_state = '0;
    rd_count = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.op_ch == CH_W'(i)) begin
        rd_state = state_q[i];
        rd_count = count_q[i];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    if (accept && op == OP_READ) begin
      out_valid_d = 1'b1;
      out_ch_d    = bus.op_ch;
      out_data_d  = ch_ok ? rd_state : '0;
      out_count_d = ch_ok ? rd_count : '0;
      out_err_d   = ~ch_ok;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_err   = out_err_q;

endmodule
